tx_arbiter: RTL and testbench

//  Shares one transmission controller (REQ/DRDY/DATA in; ACK/EXC/IDL out) between N_REQ requesters.

---
 rtl/tx_arbiter_pkg.sv | 23 ++
 rtl/tx_arbiter_rr_pick.sv | 43 ++++
 rtl/tx_arbiter.sv | 150 +++++++++++++++
 tb/tb_tx_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arbiter_pkg.sv
// Shared definitions for tx_arbiter: FSM state encoding, parameter defaults and clog2.
package tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_DW      = 8;
    localparam int DEF_TIMEOUT = 64;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest distance (k - ptr) mod N among asserted requests wins.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    int best_d;
    int d;

    always_comb begin
        best_d = N;
        d      = 0;
        idx_o  = '0;
        for (int k = 0; k < N; k++) begin
            if (req_i[k]) begin
                d = k - int'(ptr_i);
                if (d < 0) begin
                    d = d + N;
                end
                if (d < best_d) begin
                    best_d = d;
                    idx_o  = IW'(k);
                end
            end
        end
    end

    assign valid_o = |req_i;

    always_comb begin
        onehot_o = '0;
        for (int k = 0; k < N; k++) begin
            onehot_o[k] = valid_o && (idx_o == IW'(k));
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one transmission controller among N_REQ requesters.
// Optional forced-release timeout is built when TX_ARB_TIMEOUT_EN is defined (adds TO_O).
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int DW      = DEF_DW,
`ifdef TX_ARB_TIMEOUT_EN
    parameter int TIMEOUT = DEF_TIMEOUT,
`endif
    localparam int IW     = clog2(N_REQ)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                ENA,
    input  logic [N_REQ-1:0]    REQ_I,
    input  logic [N_REQ-1:0]    DRDY_I,
    input  logic [N_REQ*DW-1:0] DATA_I,
    output logic [N_REQ-1:0]    GNT_O,
    output logic [N_REQ-1:0]    ACK_O,
    output logic [N_REQ-1:0]    EXC_O,
    output logic                M_ENA,
    output logic                M_REQ,
    output logic                M_DRDY,
    output logic [DW-1:0]       M_DATA,
    input  logic                M_ACK,
    input  logic                M_EXC,
    input  logic                M_IDL,
    output logic                BUSY,
    output logic [IW-1:0]       GNT_ID,
`ifdef TX_ARB_TIMEOUT_EN
    output logic                TO_O,
`endif
    output logic [1:0]          STATE_O
);

    arb_state_e       state_q;
    logic [N_REQ-1:0] gnt_q;
    logic [IW-1:0]    gnt_id_q;
    logic [IW-1:0]    ptr_q;
    logic [IW-1:0]    ptr_d;
    logic             ena_q;
    logic             release_d;
    logic             timeout_hit;

    logic [N_REQ-1:0] pick_oh;
    logic [IW-1:0]    pick_idx;
    logic             pick_vld;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req_i    (REQ_I),
        .ptr_i    (ptr_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .valid_o  (pick_vld)
    );

`ifdef TX_ARB_TIMEOUT_EN
    localparam int CW = clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    logic          to_q;

    // Fires on the edge that would complete TIMEOUT GRANT cycles without an ACK.
    assign timeout_hit = (state_q == ST_GRANT) && !M_ACK && (cnt_q == CW'(TIMEOUT - 1));
    assign TO_O        = to_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            to_q <= timeout_hit;
            if (state_q != ST_GRANT || M_ACK) begin
                cnt_q <= '0;
            end else if (!timeout_hit) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign release_d = !(|(REQ_I & gnt_q)) || !ENA || timeout_hit;
    assign ptr_d     = (gnt_id_q == IW'(N_REQ - 1)) ? '0 : gnt_id_q + IW'(1);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= '0;
            ena_q    <= 1'b0;
        end else begin
            ena_q <= ENA;
            case (state_q)
                ST_IDLE: begin
                    if (ENA && M_IDL && pick_vld) begin
                        gnt_q    <= pick_oh;
                        gnt_id_q <= pick_idx;
                        state_q  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (release_d) begin
                        gnt_q   <= '0;
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Pointer moves past the last grant only once the controller is idle again.
                    if (M_IDL) begin
                        ptr_q   <= ptr_d;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    logic [DW-1:0] mux_data;

    always_comb begin
        mux_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_q[k]) begin
                mux_data = mux_data | DATA_I[k*DW +: DW];
            end
        end
    end

    assign GNT_O   = gnt_q;
    assign GNT_ID  = gnt_id_q;
    assign M_ENA   = ena_q;
    assign M_REQ   = |(REQ_I & gnt_q);
    assign M_DRDY  = |(DRDY_I & gnt_q);
    assign M_DATA  = mux_data;
    assign ACK_O   = gnt_q & {N_REQ{M_ACK}};
    assign EXC_O   = gnt_q & {N_REQ{M_EXC}};
    assign BUSY    = (state_q != ST_IDLE);
    assign STATE_O = state_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: reset, single grant, routing, drain hold, fairness, ENA/RESET release.
module tb_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            ena;
    logic [N-1:0]    req;
    logic [N-1:0]    drdy;
    logic [N*DW-1:0] data;
    logic            m_ack;
    logic            m_exc;
    logic            m_idl;

    logic [N-1:0]    gnt;
    logic [N-1:0]    ack_o;
    logic [N-1:0]    exc_o;
    logic            m_ena;
    logic            m_req;
    logic            m_drdy;
    logic [DW-1:0]   m_data;
    logic            busy;
    logic [1:0]      gnt_id;
    logic [1:0]      state;
`ifdef TX_ARB_TIMEOUT_EN
    logic            to_o;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tx_arbiter #(
        .N_REQ   (N),
`ifdef TX_ARB_TIMEOUT_EN
        .TIMEOUT (8),
`endif
        .DW      (DW)
    ) dut (
        .CLK     (clk),
        .RESET   (rst),
        .ENA     (ena),
        .REQ_I   (req),
        .DRDY_I  (drdy),
        .DATA_I  (data),
        .GNT_O   (gnt),
        .ACK_O   (ack_o),
        .EXC_O   (exc_o),
        .M_ENA   (m_ena),
        .M_REQ   (m_req),
        .M_DRDY  (m_drdy),
        .M_DATA  (m_data),
        .M_ACK   (m_ack),
        .M_EXC   (m_exc),
        .M_IDL   (m_idl),
        .BUSY    (busy),
        .GNT_ID  (gnt_id),
`ifdef TX_ARB_TIMEOUT_EN
        .TO_O    (to_o),
`endif
        .STATE_O (state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    int order [5] = '{0, 1, 2, 3, 0};
    int waited;

    initial begin
        rst = 1'b1; ena = 1'b0; req = 4'b1111; drdy = 4'b0000; data = '0;
        m_ack = 1'b0; m_exc = 1'b0; m_idl = 1'b1;
        tick();
        tick();
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_mreq", m_req, 1'b0);
        chk("rst_mena", m_ena, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_gntid", gnt_id, 2'd0);
        chk("rst_state", state, 2'd0);

        // Single request on requester 2
        rst = 1'b0; ena = 1'b1; req = 4'b0100; drdy = 4'b0100; data = 32'h44AA_2211;
        tick();
        chk("single_gnt", gnt, 4'b0100);
        chk("single_gntid", gnt_id, 2'd2);
        chk("single_data", m_data, 8'hAA);
        chk("single_mreq", m_req, 1'b1);
        chk("single_mdrdy", m_drdy, 1'b1);
        chk("single_mena", m_ena, 1'b1);
        chk("single_busy", busy, 1'b1);
        req = 4'b0000;
        tick();
        chk("single_drain_gnt", gnt, 4'b0000);
        chk("single_drain_mreq", m_req, 1'b0);
        chk("single_drain_state", state, 2'd2);
        tick();
        chk("single_idle_busy", busy, 1'b0);

        // Routing on requester 1 (pointer now 3)
        req = 4'b0010; drdy = 4'b0000; data = 32'h4433_2211;
        tick();
        chk("route_gnt", gnt, 4'b0010);
        chk("route_data", m_data, 8'h22);
        m_ack = 1'b1;
        #1;
        chk("route_ack", ack_o, 4'b0010);
        chk("route_ack_exc", exc_o, 4'b0000);
        tick();
        m_ack = 1'b0; m_exc = 1'b1;
        #1;
        chk("route_exc", exc_o, 4'b0010);
        chk("route_exc_ack", ack_o, 4'b0000);
        tick();
        chk("route_exc_keeps_gnt", gnt, 4'b0010);
        m_exc = 1'b0; req = 4'b0000;
        tick();
        m_ack = 1'b1; m_exc = 1'b1;
        #1;
        chk("route_drain_ack", ack_o, 4'b0000);
        chk("route_drain_exc", exc_o, 4'b0000);
        m_ack = 1'b0; m_exc = 1'b0;
        tick();

        // Drain hold: controller busy keeps the next grant back (pointer now 2)
        req = 4'b0001;
        tick();
        chk("hold_gnt0", gnt, 4'b0001);
        req = 4'b1000; m_idl = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_no_gnt", gnt, 4'b0000);
            chk("hold_state", state, 2'd2);
        end
        m_idl = 1'b1;
        tick();
        chk("hold_idle_gnt", gnt, 4'b0000);
        chk("hold_idle_state", state, 2'd0);
        tick();
        chk("hold_gnt3", gnt, 4'b1000);
        chk("hold_gntid3", gnt_id, 2'd3);
        req = 4'b0000;
        tick();
        tick();

        // Fairness: all request, each holds for 3 grant cycles (pointer now 0)
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            waited = 0;
            while (gnt == 4'b0000 && waited < 10) begin
                tick();
                waited++;
            end
            chk("fair_latency", waited, (n == 0) ? 1 : 2);
            chk("fair_gntid", gnt_id, order[n]);
            chk("fair_gnt", gnt, 1 << order[n]);
            chk("fair_data", m_data, 8'h11 * (order[n] + 1));
            tick();
            tick();
            req[order[n]] = 1'b0;
            tick();
            chk("fair_drain_gnt", gnt, 4'b0000);
            chk("fair_drain_state", state, 2'd2);
            req[order[n]] = 1'b1;
        end
        req = 4'b0000;
        tick();

        // ENA low during grant forces release; M_ENA lags ENA by one cycle (pointer now 1)
        req = 4'b0010;
        tick();
        chk("ena_gnt", gnt, 4'b0010);
        ena = 1'b0;
        #1;
        chk("ena_mena_lag", m_ena, 1'b1);
        tick();
        chk("ena_release_gnt", gnt, 4'b0000);
        chk("ena_mena_low", m_ena, 1'b0);
        chk("ena_drain_state", state, 2'd2);
        ena = 1'b1; req = 4'b0000;
        tick();

        // Reset mid-transfer (pointer now 2)
        req = 4'b0100;
        tick();
        chk("midrst_gnt", gnt, 4'b0100);
        rst = 1'b1;
        tick();
        chk("midrst_gnt_clr", gnt, 4'b0000);
        chk("midrst_mreq", m_req, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_gntid", gnt_id, 2'd0);
        rst = 1'b0; req = 4'b0000;
        tick();

        // Request withdrawn before the grant edge
        req = 4'b0001;
        #2;
        req = 4'b0000;
        tick();
        chk("withdraw_gnt", gnt, 4'b0000);
        chk("withdraw_busy", busy, 1'b0);

`ifdef TX_ARB_TIMEOUT_EN
        // Timeout = 8 with no ACK (pointer 0 after the reset above)
        req = 4'b0011;
        tick();
        chk("to_gnt0", gnt, 4'b0001);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_still_gnt", gnt, 4'b0001);
            chk("to_no_pulse", to_o, 1'b0);
        end
        tick();
        chk("to_pulse", to_o, 1'b1);
        chk("to_forced_drain", gnt, 4'b0000);
        tick();
        chk("to_pulse_end", to_o, 1'b0);
        tick();
        chk("to_next_gnt1", gnt, 4'b0010);
        req = 4'b0000;
        tick();
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
